// File: rtl/clock_ctrl_if.sv
// Button inputs and step/mode outputs of the clock controller.
// master: controller side; slave: buttons and time stages side.
interface clock_ctrl_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       sec_step;
    logic       min_step;
    logic       hour_step;
    logic       dec;
    logic       enable;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    modport master (
        input  btn_mode, btn_up, btn_down,
        output sec_step, min_step, hour_step,
        output dec, enable, sec_clr, mode, blink
    );

    modport slave (
        output btn_mode, btn_up, btn_down,
        input  sec_step, min_step, hour_step,
        input  dec, enable, sec_clr, mode, blink
    );
endinterface

// File: rtl/clock_ctrl.sv
// Clock controller: button sync/debounce, mode FSM, 1 s prescaler,
// set-mode stepping with auto-repeat, blink.
// Ports: i_clk, i_rst_n (async low), if_ctrl (clock_ctrl_if.master).
module clock_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DEB_CYC  = 500000,
    parameter int REP_DLY  = 25000000,
    parameter int REP_PER  = 5000000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    clock_ctrl_if.master  if_ctrl
);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int DW   = $clog2(DEB_CYC + 1);
    localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int RW   = $clog2(RMAX + 1);

    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DN   = 2;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    logic [2:0]         w_btn;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_deb;
    logic [2:0]         r_deb_d;
    logic [2:0][DW-1:0] r_deb_cnt;
    logic [2:0]         w_press;

    mode_t              r_mode;
    mode_t              w_mode_nxt;
    logic [PW-1:0]      r_presc;
    logic [PW-1:0]      w_presc_nxt;
    logic               r_enable;
    logic               r_sec_step;
    logic               r_min_step;
    logic               r_hour_step;
    logic               r_dec;
    logic               r_sec_clr;
    logic               r_blink;

    logic [RW-1:0]      r_rep_cnt;
    logic               r_rep_act;
    logic               r_rep_first;
    logic               r_rep_dn;

    logic               w_mode_ev;
    logic               w_both;
    logic               w_set;
    logic               w_any_press;
    logic               w_held;
    logic               w_rep_hit;
    logic               w_step;
    logic               w_step_dn;

    assign w_btn = {if_ctrl.btn_down, if_ctrl.btn_up, if_ctrl.btn_mode};

    // Press event: debounced level rose on the previous edge.
    assign w_press = r_deb & ~r_deb_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_deb_d   <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_mode_ev   = w_press[B_MODE];
    assign w_both      = r_deb[B_UP] & r_deb[B_DN];
    assign w_set       = (r_mode != RUN) & ~w_mode_ev;
    assign w_any_press = w_press[B_UP] | w_press[B_DN];
    assign w_held      = r_rep_dn ? r_deb[B_DN] : r_deb[B_UP];
    assign w_rep_hit   = r_rep_first ? (r_rep_cnt == RW'(REP_DLY - 1))
                                     : (r_rep_cnt == RW'(REP_PER - 1));

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_mode_ev) begin
            unique case (r_mode)
                RUN:      w_mode_nxt = SET_HOUR;
                SET_HOUR: w_mode_nxt = SET_MIN;
                default:  w_mode_nxt = RUN;
            endcase
        end
    end

    // Prescaler holds during the first enabled edge so the first
    // second lands TICK_DIV cycles after reset release.
    always_comb begin
        w_presc_nxt = r_presc;
        if (w_mode_ev)
            w_presc_nxt = '0;
        else if (!r_enable)
            w_presc_nxt = r_presc;
        else if (r_presc == PW'(TICK_DIV - 1))
            w_presc_nxt = '0;
        else
            w_presc_nxt = r_presc + 1'b1;
    end

    always_comb begin
        w_step    = 1'b0;
        w_step_dn = r_rep_dn;
        if (w_set && !w_both) begin
            if (w_any_press) begin
                w_step    = 1'b1;
                w_step_dn = w_press[B_DN];
            end else if (r_rep_act && w_held && w_rep_hit) begin
                w_step = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= RUN;
            r_presc     <= '0;
            r_enable    <= 1'b0;
            r_sec_step  <= 1'b0;
            r_min_step  <= 1'b0;
            r_hour_step <= 1'b0;
            r_dec       <= 1'b0;
            r_sec_clr   <= 1'b0;
            r_blink     <= 1'b0;
            r_rep_cnt   <= '0;
            r_rep_act   <= 1'b0;
            r_rep_first <= 1'b0;
            r_rep_dn    <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_presc     <= w_presc_nxt;
            r_enable    <= 1'b1;
            r_sec_step  <= (w_mode_nxt == RUN) &&
                           (w_presc_nxt == PW'(TICK_DIV - 1));
            r_blink     <= (w_mode_nxt != RUN) &&
                           (w_presc_nxt < PW'(TICK_DIV / 2));
            r_sec_clr   <= w_mode_ev && (r_mode == SET_MIN);
            r_min_step  <= w_step && (r_mode == SET_MIN);
            r_hour_step <= w_step && (r_mode == SET_HOUR);

            if (w_mode_nxt == RUN)
                r_dec <= 1'b0;
            else if (w_step)
                r_dec <= w_step_dn;

            // A mode event, RUN, or both buttons held kill any repeat;
            // only a fresh press re-arms it.
            if (!w_set || w_both) begin
                r_rep_act <= 1'b0;
                r_rep_cnt <= '0;
            end else if (w_any_press) begin
                r_rep_act   <= 1'b1;
                r_rep_first <= 1'b1;
                r_rep_dn    <= w_press[B_DN];
                r_rep_cnt   <= '0;
            end else if (r_rep_act && w_held) begin
                if (w_rep_hit) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b0;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end else begin
                r_rep_act <= 1'b0;
                r_rep_cnt <= '0;
            end
        end
    end

    assign if_ctrl.sec_step  = r_sec_step;
    assign if_ctrl.min_step  = r_min_step;
    assign if_ctrl.hour_step = r_hour_step;
    assign if_ctrl.dec       = r_dec;
    assign if_ctrl.enable    = r_enable;
    assign if_ctrl.sec_clr   = r_sec_clr;
    assign if_ctrl.mode      = r_mode;
    assign if_ctrl.blink     = r_blink;
endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 TICK_DIV, 50000000, CLK cycles per 1 s tick; SHALL be >= 4 and even.
REQ-002 DEB_CYC, 500000, consecutive stable cycles required to accept a button level change.
REQ-003 REP_DLY, 25000000, hold cycles after the first step before auto-repeat begins.
REQ-004 REP_PER, 5000000, cycles between auto-repeat steps.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 BTN_MODE, BTN_UP, BTN_DOWN  in  1 each  raw asynchronous active-high buttons.
REQ-008 SEC_STEP  out  1  one-cycle pulse feeding the seconds stage carry input.
REQ-009 MIN_STEP  out  1  one-cycle pulse feeding the minutes stage carry input in SET_MIN.
REQ-010 HOUR_STEP  out  1  one-cycle pulse feeding the hours stage carry input in SET_HOUR.
REQ-011 DEC  out  1  count direction for all stages; 1 = down.
REQ-012 ENABLE  out  1  stage enable; 1 whenever not in reset.
REQ-013 SEC_CLR  out  1  one-cycle pulse clearing the seconds stage.
REQ-014 MODE  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-015 BLINK  out  1  display blink for the field being set.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its stable level only after DEB_CYC consecutive equal synchronized samples; any mismatch restarts the count.
REQ-017 A debounced 0->1 transition SHALL produce a press event registered one cycle later, so a raw edge produces the event exactly DEB_CYC+3 cycles after its first sampling edge.
REQ-018 The mode FSM SHALL advance on a MODE press event: RUN->SET_HOUR->SET_MIN->RUN; MODE SHALL change in the same cycle as the event.
REQ-019 The prescaler SHALL count 0..TICK_DIV-1 and wrap; it SHALL load 0 on every mode change.
REQ-020 In RUN, SEC_STEP SHALL pulse in the cycle the prescaler equals TICK_DIV-1; in set modes SEC_STEP SHALL stay 0.
REQ-021 In SET_HOUR or SET_MIN, an UP or DOWN press event SHALL pulse HOUR_STEP or MIN_STEP respectively for one cycle, with DEC=0 for UP and DEC=1 for DOWN in that same cycle.
REQ-022 While the same button remains debounced-high, a repeat step SHALL occur REP_DLY cycles after the first step and then every REP_PER cycles until release.
REQ-023 If UP and DOWN are both debounced-high, no step SHALL be generated and the repeat timer SHALL be cleared; a fresh press event is required to resume.
REQ-024 DEC SHALL hold its last value between steps and SHALL be 0 in RUN.
REQ-025 A MODE event in the same cycle as an UP/DOWN event SHALL win; no step SHALL be issued in that cycle and the repeat timer SHALL be cleared.
REQ-026 The SET_MIN->RUN transition SHALL pulse SEC_CLR in the transition cycle; no other transition SHALL pulse SEC_CLR.
REQ-027 BLINK SHALL be 0 in RUN; in set modes it SHALL be 1 while the prescaler is < TICK_DIV/2 and 0 otherwise.
REQ-028 At most one of SEC_STEP, MIN_STEP, and HOUR_STEP SHALL be high in any cycle.

Reset
REQ-029 When RESET=0, the block SHALL immediately force MODE=00, all step pulses 0, SEC_CLR=0, DEC=0, ENABLE=0, BLINK=0, and the prescaler, debounce and repeat counters to 0; debounced levels SHALL be 0.
REQ-030 After release, ENABLE SHALL go to 1 on the first rising CLK edge, and reset asserted mid-hold SHALL discard any pending repeat.

Verification
REQ-031 Bench parameters SHALL be TICK_DIV=10, DEB_CYC=4, REP_DLY=20, REP_PER=5.
REQ-032 RUN, no buttons, 35 cycles after reset -> SEC_STEP pulses at cycles 10, 20, and 30; DEC=0; MIN_STEP=HOUR_STEP=0.
REQ-033 MODE pressed clean -> MODE=01 at +7 cycles; second press -> 10; third press -> 00 with a one-cycle SEC_CLR in that cycle.
REQ-034 SET_HOUR, DOWN held 40 cycles -> HOUR_STEP at event cycle t, then t+20, t+25, t+30, t+35 with DEC=1 on each; MIN_STEP=0.
REQ-035 SET_MIN, UP bouncing 3 cycles then stable -> exactly one MIN_STEP, DEC=0; UP+DOWN both held -> no steps.
REQ-036 RESET pulled low during an auto-repeat in SET_MIN -> all outputs 0 asynchronously; after release MODE=00 and no step occurs until a fresh press.
